tmds_channel_decoder: RTL and testbench
=======================================

// Module: tmds_channel_decoder
// PURPOSE
//  Receive-side counterpart of the DVI/HDMI TMDS encode path: takes one channel's raw 10-bit
//  word from the deserializer and word-aligns it by requesting bitslips until control tokens
//  repeat. It then decodes it back to 8-bit pixel data, DE and the C1:C0 control pair.
//  Three instances, one each for blue, green and red, sit in the pixel-clock domain of the receiver top.
// PARAMETERS
//  TOKEN_RUN     8      consecutive identical control tokens needed to declare alignment
//  SEARCH_LIMIT  4096   cycles in SEARCH without TOKEN_RUN before a bitslip is issued
//  SLIP_WAIT     16     cycles ignored after a bitslip, while the deserializer settles
//  LOSS_LIMIT    65536  cycles in LOCKED with no control token before lock is dropped
// PORTS
//  CLK         in   1   pixel clock (pclk); all logic on rising edge
//  RST         in   1   synchronous reset, active-high
//  din         in   10  raw TMDS word from deserializer, bit 0 = first bit on the wire
//  bitslip     out  1   one-cycle pulse: deserializer rotates word boundary by one bit
//  locked      out  1   word alignment achieved
//  slip_wrap   out  1   one-cycle pulse when the 10th consecutive slip occurs without lock
//  dout        out  8   decoded pixel data (valid when de=1)
//  de          out  1   data enable (1 = video word, 0 = control token)
//  c0, c1      out  1   decoded control bits (valid when de=0; hold last value when de=1)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=SEARCH; all counters 0; slip counter 0.
//  Tokens (din[9:0]): 0x354->C1C0=00, 0x0AB->01, 0x154->10, 0x2AB->11; any other word is data.
//  FSM:
//   SEARCH: run_cnt increments when din is a token equal to the previous cycle's din,
//     and reloads to 1 on a new token or to 0 on a non-token.
//     - When run_cnt reaches TOKEN_RUN: go to LOCKED and clear the slip counter.
//     - Otherwise, when search_cnt reaches SEARCH_LIMIT-1: pulse bitslip, increment the
//       slip counter mod 10, and go to SLIP.
//       - If the slip counter wraps 9->0, pulse slip_wrap in the same cycle.
//   SLIP: wait SLIP_WAIT cycles (din ignored, run_cnt held 0), then go to SEARCH with
//     search_cnt=0.
//   LOCKED: locked=1. loss_cnt clears on any token and increments otherwise.
//     - When loss_cnt reaches LOSS_LIMIT-1: locked=0, go to SEARCH with all counters 0.
//  bitslip is never asserted in consecutive cycles; it is asserted at most once per SLIP_WAIT+1 cycles.
//  Decode, registered with 1-cycle latency from din to dout/de/c0/c1, computed in every state:
//   - token: de=0, c1/c0 from the table above, dout=0.
//   - data: de=1. Let d = din[9] ? ~din[7:0] : din[7:0]. Then dout[0]=d[0] and, for i=1..7,
//     dout[i] = din[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
//  While locked=0, de/dout/c0/c1 are forced to 0 at the output register.
//  Simultaneous events: in SEARCH, run_cnt reaching TOKEN_RUN and search_cnt reaching its
//   limit in the same cycle -> LOCKED wins and no bitslip is issued.
//  RST mid-operation: on the next edge all outputs are 0 and the FSM is in SEARCH; a bitslip
//   pulse in flight is cancelled.
//  Counters are sized as clog2(param) bits and saturate, never wrap, except the slip counter (mod 10).
// TESTING
//  1. Aligned stream, 20 x 0x354 then data 0x1F0 -> locked at cycle TOKEN_RUN+1;
//     then de=0, c1c0=00, then de=1, dout=0x10 one cycle later.
//  2. Stream rotated by 3 bits, bench model rotates on each bitslip -> exactly 3 bitslip pulses
//     spaced >=SEARCH_LIMIT apart, then locked=1.
//  3. Random non-token data only -> 10 bitslips, slip_wrap pulse on the 10th, locked stays 0,
//     de/dout stay 0.
//  4. Locked, then LOSS_LIMIT cycles of data words -> locked falls on cycle LOSS_LIMIT and
//     outputs are forced 0 the next cycle.
//  5. All 256 bytes through a reference TMDS encoder model (both DC-balance branches) ->
//     dout equals the original byte with 1-cycle latency.
//  6. RST asserted in SLIP and in LOCKED -> all outputs 0 next cycle; normal lock is reacquired after release.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment via bitslip search, then token/data decode.
// One instance per colour channel, all logic in the pixel-clock domain.
module tmds_channel_decoder #(
    parameter int TOKEN_RUN    = 8,
    parameter int SEARCH_LIMIT = 4096,
    parameter int SLIP_WAIT    = 16,
    parameter int LOSS_LIMIT   = 65536
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] din,
    output logic       bitslip,
    output logic       locked,
    output logic       slip_wrap,
    output logic [7:0] dout,
    output logic       de,
    output logic       c0,
    output logic       c1
);

    localparam int RW = $clog2(TOKEN_RUN + 1);
    localparam int SW = $clog2(SEARCH_LIMIT);
    localparam int WW = $clog2(SLIP_WAIT);
    localparam int LW = $clog2(LOSS_LIMIT);

    localparam logic [RW-1:0] RUN_MAX  = RW'(TOKEN_RUN);
    localparam logic [SW-1:0] SRCH_MAX = SW'(SEARCH_LIMIT - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(SLIP_WAIT - 1);
    localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_LIMIT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [SW-1:0] search_q, search_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [LW-1:0] loss_q, loss_d;
    logic [3:0]    slip_q, slip_d;
    logic [9:0]    prev_q, prev_d;
    logic          bitslip_q, bitslip_d;
    logic          wrap_q, wrap_d;
    logic [7:0]    dout_q, dout_d;
    logic          de_q, de_d;
    logic          c0_q, c0_d;
    logic          c1_q, c1_d;

    logic          is_tok;
    logic [1:0]    tok_c;
    logic [7:0]    d;
    logic [7:0]    dec;

    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (din)
            10'h354: tok_c = 2'b00;
            10'h0AB: tok_c = 2'b01;
            10'h154: tok_c = 2'b10;
            10'h2AB: tok_c = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        d      = din[9] ? ~din[7:0] : din[7:0];
        dec    = 8'h00;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = din[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        search_d  = search_q;
        wait_d    = wait_q;
        loss_d    = loss_q;
        slip_d    = slip_q;
        prev_d    = din;
        bitslip_d = 1'b0;
        wrap_d    = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (!is_tok) begin
                    run_d = '0;
                end else if (din == prev_q) begin
                    run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
                end else begin
                    run_d = RW'(1);
                end
                search_d = (search_q == SRCH_MAX) ? search_q : search_q + 1'b1;
                if (run_d == RUN_MAX) begin
                    state_d  = LOCKED;
                    slip_d   = '0;
                    loss_d   = '0;
                    run_d    = '0;
                    search_d = '0;
                end else if (search_q == SRCH_MAX) begin
                    state_d   = SLIP;
                    bitslip_d = 1'b1;
                    wrap_d    = (slip_q == 4'd9);
                    slip_d    = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                    wait_d    = '0;
                    run_d     = '0;
                    search_d  = '0;
                end
            end
            SLIP: begin
                run_d  = '0;
                wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                if (wait_q == WAIT_MAX) begin
                    state_d  = SEARCH;
                    wait_d   = '0;
                    search_d = '0;
                end
            end
            LOCKED: begin
                loss_d = is_tok ? '0
                       : (loss_q == LOSS_MAX) ? loss_q : loss_q + 1'b1;
                if (loss_d == LOSS_MAX) begin
                    state_d  = SEARCH;
                    loss_d   = '0;
                    run_d    = '0;
                    search_d = '0;
                    wait_d   = '0;
                    slip_d   = '0;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Decoded outputs are gated by the current lock state.
    always_comb begin
        dout_d = 8'h00;
        de_d   = 1'b0;
        c0_d   = 1'b0;
        c1_d   = 1'b0;
        if (state_q == LOCKED) begin
            if (is_tok) begin
                {c1_d, c0_d} = tok_c;
            end else begin
                de_d   = 1'b1;
                dout_d = dec;
                c0_d   = c0_q;
                c1_d   = c1_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= SEARCH;
            run_q     <= '0;
            search_q  <= '0;
            wait_q    <= '0;
            loss_q    <= '0;
            slip_q    <= '0;
            prev_q    <= '0;
            bitslip_q <= 1'b0;
            wrap_q    <= 1'b0;
            dout_q    <= '0;
            de_q      <= 1'b0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            search_q  <= search_d;
            wait_q    <= wait_d;
            loss_q    <= loss_d;
            slip_q    <= slip_d;
            prev_q    <= prev_d;
            bitslip_q <= bitslip_d;
            wrap_q    <= wrap_d;
            dout_q    <= dout_d;
            de_q      <= de_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
        end
    end

    assign bitslip   = bitslip_q;
    assign slip_wrap = wrap_q;
    assign locked    = (state_q == LOCKED);
    assign dout      = dout_q;
    assign de        = de_q;
    assign c0        = c0_q;
    assign c1        = c1_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder with a deserializer/bitslip model
// and a TMDS encoder reference; runs with shortened limits.
module tb_tmds_channel_decoder;

    localparam int TR = 8;
    localparam int SL = 64;
    localparam int SW = 16;
    localparam int LL = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = 10'h000;
    logic       bitslip, locked, slip_wrap, de, c0, c1;
    logic [7:0] dout;

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .TOKEN_RUN(TR), .SEARCH_LIMIT(SL), .SLIP_WAIT(SW), .LOSS_LIMIT(LL)
    ) dut (
        .CLK(clk), .RST(rst), .din(din), .bitslip(bitslip), .locked(locked),
        .slip_wrap(slip_wrap), .dout(dout), .de(de), .c0(c0), .c1(c1)
    );

    typedef struct packed {
        logic       lk;
        logic       bs;
        logic       wr;
        logic       de;
        logic       c1;
        logic       c0;
        logic [7:0] dout;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_bs = 0;
    int n_wrap = 0;
    int n_de = 0;
    int last_bs = -1;
    int min_gap = 1000000;
    int rot = 0;

    // reference state: mode 0 = hunting, 1 = settling after slip, 2 = aligned
    int m_mode = 0, m_run = 0, m_search = 0, m_wait = 0, m_loss = 0;
    int m_slips = 0, m_bs_total = 0;
    logic [9:0] m_prev = 10'h000;
    logic m_c1 = 1'b0, m_c0 = 1'b0;

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] qm, b;
        qm = w[9] ? ~w[7:0] : w[7:0];
        b[0] = qm[0];
        for (int i = 1; i < 8; i++) b[i] = qm[i] ^ qm[i-1] ^ ~w[8];
        return b;
    endfunction

    function automatic logic [8:0] tmds_qm(input logic [7:0] b);
        logic [8:0] qm;
        int n1;
        bit xn;
        n1 = $countones(b);
        xn = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        qm[8] = !xn;
        return qm;
    endfunction

    function automatic logic [9:0] rot10(input logic [9:0] w, input int r);
        logic [19:0] x;
        x = {w, w};
        return x[r +: 10];
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        while (tok_code(w) >= 0) w = 10'($urandom);
        return w;
    endfunction

    task automatic step(input logic [9:0] w, input bit r, input bit ovr, input logic [7:0] ob);
        exp_t e;
        int t;
        e = '0;
        if (r) begin
            m_mode = 0; m_run = 0; m_search = 0; m_wait = 0; m_loss = 0; m_slips = 0;
            m_prev = 10'h000; m_c1 = 1'b0; m_c0 = 1'b0;
            q.push_back(e);
            return;
        end
        t = tok_code(w);
        if (m_mode == 2) begin
            if (t >= 0) begin
                m_c1 = t[1];
                m_c0 = t[0];
            end else begin
                e.de = 1'b1;
                e.dout = ovr ? ob : ref_decode(w);
            end
            e.c1 = m_c1;
            e.c0 = m_c0;
        end else begin
            m_c1 = 1'b0;
            m_c0 = 1'b0;
        end
        if (m_mode == 2) begin
            m_loss = (t >= 0) ? 0 : m_loss + 1;
            if (m_loss == LL - 1) begin
                m_mode = 0; m_loss = 0; m_run = 0; m_search = 0;
            end
        end else if (m_mode == 0) begin
            if (t < 0) m_run = 0;
            else if (w == m_prev) m_run = m_run + 1;
            else m_run = 1;
            if (m_run == TR) begin
                m_mode = 2; m_slips = 0; m_loss = 0; m_run = 0; m_search = 0;
            end else if (m_search == SL - 1) begin
                e.bs = 1'b1;
                e.wr = (m_slips == 9);
                m_slips = (m_slips + 1) % 10;
                m_bs_total++;
                m_mode = 1; m_wait = 0; m_run = 0; m_search = 0;
            end else begin
                m_search++;
            end
        end else begin
            m_wait++;
            if (m_wait == SW) begin
                m_mode = 0; m_wait = 0; m_search = 0;
            end
        end
        m_prev = w;
        e.lk = (m_mode == 2);
        q.push_back(e);
    endtask

    // The deserializer model shifts its word boundary whenever the DUT asks.
    task automatic drive(input logic [9:0] w, input bit r = 1'b0,
                         input bit ovr = 1'b0, input logic [7:0] ob = 8'h00);
        @(negedge clk);
        if (bitslip === 1'b1) rot = (rot + 1) % 10;
        din = rot10(w, rot);
        rst = r;
        step(din, r, ovr, ob);
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        drive(10'h000, 1'b1);
        drive(10'h000, 1'b1);
        rot = 0;
    endtask

    initial begin : monitor
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            got = {locked, bitslip, slip_wrap, de, c1, c0, dout};
            if (bitslip === 1'b1) begin
                if (last_bs >= 0 && cyc - last_bs < min_gap) min_gap = cyc - last_bs;
                last_bs = cyc;
                n_bs++;
            end
            if (slip_wrap === 1'b1) n_wrap++;
            if (de === 1'b1) n_de++;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL sb cyc=%0d got=%h exp=%h", cyc, got, e);
                end
            end
        end
    end

    initial begin : stim
        int s_bs, s_wr, s_de;
        logic [8:0] qm;
        do_reset();
        peek();
        chk("reset_out", {locked, bitslip, slip_wrap, de, c1, c0, dout}, 0);

        // aligned stream, lock after TR tokens
        for (int k = 1; k <= 20; k++) begin
            drive(10'h354);
            if (k == TR - 1) begin
                peek();
                chk("t1_prelock", locked, 0);
            end
            if (k == TR) begin
                peek();
                chk("t1_lock", locked, 1);
            end
        end
        peek();
        chk("t1_ctl", {de, c1, c0}, 3'b000);
        drive(10'h1F0);
        peek();
        chk("t1_data", {de, dout}, {1'b1, 8'h10});

        // every byte through both DC-balance forms of the encoder
        s_de = n_de;
        for (int b = 0; b < 256; b++) begin
            qm = tmds_qm(8'(b));
            drive({1'b0, qm}, 1'b0, 1'b1, 8'(b));
            drive({1'b1, qm[8], ~qm[7:0]}, 1'b0, 1'b1, 8'(b));
            if (b % 32 == 31) drive(10'h154);
        end
        peek();
        chk("t5_de_count", n_de - s_de, 512);
        chk("t5_ctl", {c1, c0}, 2'b10);

        // lock loss after LL data words
        for (int k = 1; k <= LL; k++) begin
            drive(rand_data());
            if (k == LL - 2) begin
                peek();
                chk("t4_still", locked, 1);
            end
            if (k == LL - 1) begin
                peek();
                chk("t4_drop", {locked, de}, 2'b01);
            end
            if (k == LL) begin
                peek();
                chk("t4_forced", {de, dout, c1, c0}, 0);
            end
        end

        // misaligned by three slips
        do_reset();
        rot = 7;
        s_bs = n_bs;
        last_bs = -1;
        min_gap = 1000000;
        for (int i = 0; i < 3 * (SL + SW) + 4 * TR; i++) begin
            drive(10'h354);
            if (m_mode == 2) break;
        end
        peek();
        chk("t2_locked", locked, 1);
        chk("t2_slips", n_bs - s_bs, 3);
        chk("t2_gap", min_gap >= SL, 1);

        // data only: ten slips, one wrap, never locked
        do_reset();
        s_bs = n_bs;
        s_wr = n_wrap;
        s_de = n_de;
        for (int i = 0; i < 12 * (SL + SW); i++) begin
            drive(rand_data());
            if (m_bs_total > 0 && m_slips == 0 && m_mode == 1) break;
        end
        peek();
        chk("t3_slips", n_bs - s_bs, 10);
        chk("t3_wrap", n_wrap - s_wr, 1);
        chk("t3_de", n_de - s_de, 0);
        chk("t3_locked", locked, 0);

        // reset while a slip is in flight
        for (int i = 0; i < SL + SW + 8; i++) begin
            drive(rand_data());
            if (m_mode == 1) break;
        end
        drive(rand_data(), 1'b1);
        peek();
        chk("t6_rst_slip", {locked, bitslip, slip_wrap, de, c1, c0, dout}, 0);
        rot = 0;

        // lock and slip decision land on the same cycle
        s_bs = n_bs;
        for (int k = 0; k < SL; k++) begin
            if (k < SL - TR) drive(rand_data());
            else drive(10'h0AB);
        end
        peek();
        chk("t6_tie_lock", locked, 1);
        chk("t6_tie_noslip", n_bs - s_bs, 0);
        drive(10'h2AB);
        drive(10'h3F0);
        peek();
        chk("t6_hold_c", {de, c1, c0}, 3'b111);

        // reset while locked, then relock
        drive(10'h354, 1'b1);
        peek();
        chk("t6_rst_lock", {locked, bitslip, slip_wrap, de, c1, c0, dout}, 0);
        rot = 0;
        for (int k = 0; k < TR + 2; k++) drive(10'h154);
        peek();
        chk("t6_relock", locked, 1);

        repeat (2) @(posedge clk);
        #3;
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
